traffic_conflict_monitor: RTL
=============================

Name: traffic_conflict_monitor

Overview:
Independent safety checker on the light outputs of the highway/farm traffic light controller. It reads both 3-bit light buses every clock and checks for illegal encodings, conflicting greens/yellows, illegal phase sequences and short yellows. On the first violation it latches a fault code, counts the event and drives a blink output used to force the signal heads to flashing red.

Parameters:
MIN_YEL_CYC, 8, minimum consecutive clk cycles a road must show yellow before going red
MAX_FGRE_CYC, 48, maximum consecutive clk cycles farm green may last (used only with the watchdog feature)
FLASH_DIV, 4, clk cycles per half-period of the blink output while faulted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
light_highway  in  3  highway light code: 3'b100 red, 3'b010 yellow, 3'b001 green
light_farm  in  3  farm light code, same encoding
clear  in  1  single-cycle fault clear request
fault  out  1  latched fault flag
fault_code  out  3  0 none, 1 ENC, 2 CONFLICT, 3 SEQ, 4 YEL_SHORT, 5 WDOG
fault_cnt  out  8  saturating count of fault entries
blink  out  1  flashing drive; 0 unless faulted

Behaviour:
- Reset (async, rst_n low): fault=0, fault_code=0, fault_cnt=0, blink=0, state=INIT, all history and counters cleared.
- FSM states INIT, MONITOR, FAULT:
  - INIT lasts exactly one cycle. It captures both lights into history, runs only the stateless checks (ENC, CONFLICT), then goes to MONITOR or FAULT.
  - MONITOR runs all checks every cycle.
  - FAULT holds until clear.
- Checks, evaluated on the current inputs against the history registers, in priority order (lowest number wins on simultaneous violations):
  - ENC: either bus is not one of 100/010/001.
  - CONFLICT: both buses are non-red at the same time.
  - SEQ: a road changes with anything other than G->Y, Y->R or R->G.
  - YEL_SHORT: a road goes Y->R with yel_cnt < MIN_YEL_CYC.
  - WDOG: the watchdog condition (see Optional Feature).
- Latency: a violation on the input in cycle N shows fault=1 and fault_code from cycle N+1. fault_cnt increments (saturating at 255) in the same cycle, on FAULT entry only. Violations while already in FAULT are ignored and do not change the code.
- Per-road yel_cnt:
  - loads 1 on the first yellow cycle and increments each further consecutive yellow cycle;
  - saturates at its maximum value, width $clog2(MIN_YEL_CYC+1)+1;
  - clears when the road is not yellow.
- History updates every cycle in every state.
- blink: in FAULT it toggles every FLASH_DIV cycles, starting at 1 on the entry cycle. It is 0 in other states and the divider resets on FAULT exit.
- clear: takes priority over new violations. A clear in cycle N gives fault=0, fault_code=0, blink=0 from N+1 and state=INIT, so history is recaptured. fault_cnt is not cleared. If the violation persists, it re-faults at N+2 via the INIT checks.
- clear in MONITOR or INIT has no effect.
- Reset mid-fault returns everything to reset values.

Optional Feature:
- Macro MONITOR_WATCHDOG_EN.
- When defined: a farm-green counter (loads 1 on entering green, increments while green, clears otherwise) raises WDOG when it reaches MAX_FGRE_CYC+1.
- When undefined: the counter logic is absent and code 5 is never produced.

Decomposition:
- Package traffic_pkg holds:
  - light encodings LIGHT_RED/LIGHT_YEL/LIGHT_GRE;
  - FSM state constants;
  - fault code constants FLT_NONE..FLT_WDOG.
- Sub-module road_phase_tracker, instantiated once per road:
  - holds the history register and yel_cnt (plus the green counter on the farm instance);
  - outputs enc_err, seq_err, yel_short.
- The top level handles conflict, priority, the FSM, the counters and blink.

Test Plan:
- Full legal cycle (highway G 20, Y 10, R; farm G 15, Y 10, R; repeated twice) -> fault stays 0, fault_code 0, fault_cnt 0, blink 0.
- light_highway=3'b011 for 1 cycle at N -> fault=1 and fault_code=1 at N+1, fault_cnt=1, blink 1/0 toggling every 4 cycles.
- highway=001 and farm=001 together -> fault_code=2. A further ENC violation in FAULT leaves fault_code=2 and fault_cnt=1.
- Highway G->R directly with farm red -> fault_code=3. clear pulse at N -> fault=0 at N+1. With legal inputs it stays 0; with highway at 3'b000 it re-faults at N+2 with code 1 and fault_cnt=2.
- Highway yellow 5 cycles then red (MIN_YEL_CYC=8) -> fault_code=4; yellow exactly 8 cycles -> no fault.
- Farm green 49 cycles: with MONITOR_WATCHDOG_EN -> fault_code=5 on cycle 49+1; without it -> no fault. Async rst_n low mid-FAULT -> all outputs 0 immediately.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light conflict monitor: light codes, FSM states, fault codes.
// Optional watchdog build macro: MONITOR_WATCHDOG_EN.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRE = 3'b001;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } mon_state_e;

  localparam logic [2:0] FLT_NONE      = 3'd0;
  localparam logic [2:0] FLT_ENC       = 3'd1;
  localparam logic [2:0] FLT_CONFLICT  = 3'd2;
  localparam logic [2:0] FLT_SEQ       = 3'd3;
  localparam logic [2:0] FLT_YEL_SHORT = 3'd4;
  localparam logic [2:0] FLT_WDOG      = 3'd5;

  function automatic logic light_legal(input logic [2:0] light);
    logic ok;
    case (light)
      LIGHT_RED, LIGHT_YEL, LIGHT_GRE: ok = 1'b1;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Holding the same light is always allowed; changes must follow G->Y->R->G.
  function automatic logic step_legal(input logic [2:0] prev, input logic [2:0] cur);
    logic ok;
    if (cur == prev) begin
      ok = 1'b1;
    end else begin
      ok = ((prev == LIGHT_GRE) && (cur == LIGHT_YEL)) ||
           ((prev == LIGHT_YEL) && (cur == LIGHT_RED)) ||
           ((prev == LIGHT_RED) && (cur == LIGHT_GRE));
    end
    return ok;
  endfunction

endpackage

// File: rtl/road_phase_tracker.sv
// Per-road light history, yellow-duration counter and optional green watchdog counter.
// Green watchdog exists only when MONITOR_WATCHDOG_EN is defined and GRE_LIMIT > 0.
module road_phase_tracker
  import traffic_pkg::*;
#(
  parameter int MIN_YEL_CYC = 8,
  parameter int GRE_LIMIT   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] light,
  output logic       enc_err,
  output logic       seq_err,
  output logic       yel_short,
  output logic       gre_long
);

  localparam int YW = $clog2(MIN_YEL_CYC + 1) + 1;
  localparam logic [YW-1:0] YEL_MAX = {YW{1'b1}};
  localparam logic [YW-1:0] YEL_ONE = {{(YW-1){1'b0}}, 1'b1};

  logic [2:0]    hist_r;
  logic [YW-1:0] yel_cnt_r;

  // Light history and consecutive-yellow counter, updated every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r    <= 3'b000;
      yel_cnt_r <= {YW{1'b0}};
    end else begin
      hist_r <= light;
      if (light != LIGHT_YEL) begin
        yel_cnt_r <= {YW{1'b0}};
      end else if (yel_cnt_r != YEL_MAX) begin
        yel_cnt_r <= yel_cnt_r + YEL_ONE;
      end else begin
        yel_cnt_r <= yel_cnt_r;
      end
    end
  end

  assign enc_err   = !light_legal(light);
  assign seq_err   = light_legal(light) && !step_legal(hist_r, light);
  assign yel_short = (hist_r == LIGHT_YEL) && (light == LIGHT_RED) &&
                     (yel_cnt_r < YW'(MIN_YEL_CYC));

`ifdef MONITOR_WATCHDOG_EN
  generate
    if (GRE_LIMIT > 0) begin : g_gre_wdog
      localparam int GW = $clog2(GRE_LIMIT + 2);
      localparam logic [GW-1:0] GRE_SAT = GW'(GRE_LIMIT + 1);
      localparam logic [GW-1:0] GRE_ONE = {{(GW-1){1'b0}}, 1'b1};
      logic [GW-1:0] gre_cnt_r;

      // Consecutive-green counter; saturates one past the limit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          gre_cnt_r <= {GW{1'b0}};
        end else if (light != LIGHT_GRE) begin
          gre_cnt_r <= {GW{1'b0}};
        end else if (gre_cnt_r != GRE_SAT) begin
          gre_cnt_r <= gre_cnt_r + GRE_ONE;
        end else begin
          gre_cnt_r <= gre_cnt_r;
        end
      end

      // Current cycle is green number gre_cnt_r+1; trip when that exceeds the limit.
      assign gre_long = (light == LIGHT_GRE) && (gre_cnt_r >= GW'(GRE_LIMIT));
    end else begin : g_no_gre_wdog
      assign gre_long = 1'b0;
    end
  endgenerate
`else
  assign gre_long = 1'b0;
`endif

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor on highway/farm light buses; latches the first fault and drives a blink.
// Build macro MONITOR_WATCHDOG_EN adds the farm-green watchdog (fault code 5).
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YEL_CYC  = 8,
  parameter int MAX_FGRE_CYC = 48,
  parameter int FLASH_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] light_highway,
  input  logic [2:0] light_farm,
  input  logic       clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_cnt,
  output logic       blink
);

  localparam int DW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FLASH_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = {{(DW-1){1'b0}}, 1'b1};

  mon_state_e    state_r, state_nxt_s;
  logic [2:0]    viol_code_s;
  logic          hw_enc_s, hw_seq_s, hw_ysh_s, hw_gre_s;
  logic          fm_enc_s, fm_seq_s, fm_ysh_s, fm_gre_s;
  logic          conflict_s;

  logic          fault_r, fault_nxt_s;
  logic [2:0]    fault_code_r, code_nxt_s;
  logic [7:0]    fault_cnt_r, cnt_nxt_s;
  logic          blink_r, blink_nxt_s;
  logic [DW-1:0] div_r, div_nxt_s;

  road_phase_tracker #(
    .MIN_YEL_CYC(MIN_YEL_CYC),
    .GRE_LIMIT  (0)
  ) u_highway (
    .clk      (clk),
    .rst_n    (rst_n),
    .light    (light_highway),
    .enc_err  (hw_enc_s),
    .seq_err  (hw_seq_s),
    .yel_short(hw_ysh_s),
    .gre_long (hw_gre_s)
  );

  road_phase_tracker #(
    .MIN_YEL_CYC(MIN_YEL_CYC),
    .GRE_LIMIT  (MAX_FGRE_CYC)
  ) u_farm (
    .clk      (clk),
    .rst_n    (rst_n),
    .light    (light_farm),
    .enc_err  (fm_enc_s),
    .seq_err  (fm_seq_s),
    .yel_short(fm_ysh_s),
    .gre_long (fm_gre_s)
  );

  assign conflict_s = (light_highway != LIGHT_RED) && (light_farm != LIGHT_RED);

  // Prioritised violation code; history-based checks only apply in MONITOR.
  always_comb begin
    viol_code_s = FLT_NONE;
    if (hw_enc_s || fm_enc_s) begin
      viol_code_s = FLT_ENC;
    end else if (conflict_s) begin
      viol_code_s = FLT_CONFLICT;
    end else if (state_r != ST_MONITOR) begin
      viol_code_s = FLT_NONE;
    end else if (hw_seq_s || fm_seq_s) begin
      viol_code_s = FLT_SEQ;
    end else if (hw_ysh_s || fm_ysh_s) begin
      viol_code_s = FLT_YEL_SHORT;
    end else if (hw_gre_s || fm_gre_s) begin
      viol_code_s = FLT_WDOG;
    end else begin
      viol_code_s = FLT_NONE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: clear only acts in FAULT and beats any new violation.
  always_comb begin
    state_nxt_s = ST_INIT;
    case (state_r)
      ST_INIT, ST_MONITOR: state_nxt_s = (viol_code_s != FLT_NONE) ? ST_FAULT : ST_MONITOR;
      ST_FAULT:            state_nxt_s = clear ? ST_INIT : ST_FAULT;
      default:             state_nxt_s = ST_INIT;
    endcase
  end

  // Output next values: latch code on entry, hold in FAULT, blink divider.
  always_comb begin
    fault_nxt_s = (state_nxt_s == ST_FAULT);
    code_nxt_s  = fault_code_r;
    cnt_nxt_s   = fault_cnt_r;
    blink_nxt_s = 1'b0;
    div_nxt_s   = {DW{1'b0}};
    if (state_nxt_s != ST_FAULT) begin
      code_nxt_s = FLT_NONE;
    end else if (state_r != ST_FAULT) begin
      code_nxt_s  = viol_code_s;
      cnt_nxt_s   = (fault_cnt_r == 8'hFF) ? 8'hFF : (fault_cnt_r + 8'd1);
      blink_nxt_s = 1'b1;
    end else if (div_r == DIV_LAST) begin
      blink_nxt_s = ~blink_r;
    end else begin
      blink_nxt_s = blink_r;
      div_nxt_s   = div_r + DIV_ONE;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r      <= 1'b0;
      fault_code_r <= FLT_NONE;
      fault_cnt_r  <= 8'd0;
      blink_r      <= 1'b0;
      div_r        <= {DW{1'b0}};
    end else begin
      fault_r      <= fault_nxt_s;
      fault_code_r <= code_nxt_s;
      fault_cnt_r  <= cnt_nxt_s;
      blink_r      <= blink_nxt_s;
      div_r        <= div_nxt_s;
    end
  end

  assign fault      = fault_r;
  assign fault_code = fault_code_r;
  assign fault_cnt  = fault_cnt_r;
  assign blink      = blink_r;

endmodule
